fp_mul_seq: RTL and testbench
=============================

Name: fp_mul_seq

Overview:
- Multi-cycle sequencer for IEEE-754 binary multiply. Default format is half precision.
- Accepts an operand pair on a valid/ready handshake and classifies both operands as NORMAL/SUBNORMAL/ZERO/INFINITY/QNAN/SNAN.
- Multiplies significands with a shift-add loop, then normalizes, rounds and packs the result.
- Sits between the CPU FP issue logic and the register-file writeback; one operation in flight at a time.

Parameters:
- NEXP, 5, exponent field width.
- NSIG, 10, stored fraction width. Significand is NSIG+1 bits with the hidden bit.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  NEXP+NSIG+1  operand A.
- b  in  NEXP+NSIG+1  operand B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- y  out  NEXP+NSIG+1  packed product.
- flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, y=0, flags=0, internal registers cleared.
- Reset mid-operation: the operation is dropped and no result is produced. Same reset values apply.
- Accept: the clock edge where in_valid & in_ready. a and b are registered and the FSM moves to UNPACK.
- Inputs are ignored in every other state. in_ready=0 outside IDLE.
- States and transitions:
  - IDLE -> UNPACK on accept.
  - UNPACK, 1 cycle:
    - Classify both operands; sign = sa^sb.
    - Unbiased exponent: e-BIAS for normal, EMIN=1-BIAS for subnormal. BIAS=2^(NEXP-1)-1.
    - Significand: {1,m} for normal, {0,m} for subnormal.
    - Special cases go directly to DONE (a-side checks first; NaN takes priority over all other rules):
      - Either operand SNAN, or INF*ZERO -> canonical qNaN (exp all ones, frac MSB 1, rest 0, sign 0), invalid=1.
      - Either operand QNAN -> canonical qNaN, no flags.
      - Either operand INF -> signed infinity.
      - Either operand ZERO -> signed zero.
    - Otherwise -> MUL with exponent sum = ea+eb.
  - MUL, exactly NSIG+1 cycles:
    - Counter-driven shift-add of the two (NSIG+1)-bit significands into a 2*(NSIG+1)-bit product.
    - One multiplier bit per cycle, LSB first. Then -> NORM.
  - NORM:
    - If product MSB is set: shift right 1, exponent+1, 1 cycle.
    - Else left-shift 1 bit/cycle, exponent-1, until bit 2*NSIG is set.
    - A nonzero product always terminates. Normal*normal takes exactly 1 cycle. Then -> ROUND.
  - ROUND, 1 cycle:
    - Keep NSIG fraction bits plus guard and sticky (OR of the rest); round-to-nearest-even.
    - inexact = guard|sticky.
    - A rounding carry to 2.0 renormalizes: exponent+1.
    - Exponent > BIAS -> signed infinity; overflow=1, inexact=1.
    - Exponent < EMIN -> signed zero (flush, no subnormal results); underflow=1, inexact=1.
    - Else pack the biased exponent. -> DONE.
  - DONE: out_valid=1, y and flags stable. -> IDLE on out_ready. No accept is possible in the DONE cycle.
- Latency, accept edge to out_valid high:
  - NSIG+5 cycles for normal operands (15 by default).
  - Plus k cycles for k left shifts.
  - 2 cycles for special cases.
- Throughput: at most one result per latency+1 cycles.
- out_valid deasserts the cycle after the out_ready handshake. y and flags keep their last value until overwritten at the next DONE entry.
- Exponent arithmetic is signed, NEXP+2 bits wide; no wrap within legal ranges.

Test Plan:
- Reset high for 2 cycles during MUL -> out_valid=0, in_ready=1 the next cycle, y=0. A new accept then completes normally.
- a=0x3C00, b=0x3E00 -> y=0x3E00, flags=0, out_valid 15 cycles after accept. a=0x4000, b=0x4200 -> y=0x4600.
- a=0xC000, b=0x3800 -> y=0xBC00. Hold out_ready=0 for 5 cycles -> y stable and out_valid held; IDLE after the handshake.
- a=0x7C00, b=0x0000 -> y=0x7E00, invalid=1, 2-cycle latency. a=0x7D00 (sNaN), b=0x3C00 -> y=0x7E00, invalid=1. a=0x7E00, b=0x3C00 -> y=0x7E00, flags=0.
- a=0x7BFF, b=0x7BFF -> y=0x7C00, overflow=1, inexact=1. a=0x0400, b=0x3800 -> y=0x0000, underflow=1.
- a=0x0001, b=0x3C00 -> NORM takes 11 cycles, y=0x0000, underflow=1. in_valid pulses during busy cycles are ignored.

Source files
------------

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier: unpack/classify, shift-add significand product,
// normalize, round-to-nearest-even, pack. One operation in flight at a time.
module fp_mul_seq #(
    parameter int NEXP = 5,
    parameter int NSIG = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NEXP+NSIG:0]   a,
    input  logic [NEXP+NSIG:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NEXP+NSIG:0]   y,
    output logic [3:0]           flags
);
    localparam int W  = NEXP + NSIG + 1;
    localparam int SW = NSIG + 1;
    localparam int PW = 2 * SW;
    localparam int EW = NEXP + 2;
    localparam int CW = $clog2(NSIG + 1);
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (NEXP - 1)) - 1);
    localparam logic signed [EW-1:0] EMIN = ONE - BIAS;
    localparam logic [W-1:0] QNAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;
    typedef enum logic [2:0] {C_NORMAL, C_SUB, C_ZERO, C_INF, C_QNAN, C_SNAN} cls_t;

    state_t                 r_state, w_state_next;
    logic [W-1:0]           r_a, r_b, r_y;
    logic [3:0]             r_flags;
    logic                   r_sign, r_sticky;
    logic signed [EW-1:0]   r_exp;
    logic [PW-1:0]          r_mcand, r_prod;
    logic [SW-1:0]          r_mplier;
    logic [CW-1:0]          r_cnt;

    logic [W-1:0]           w_op   [2];
    cls_t                   w_cls  [2];
    logic signed [EW-1:0]   w_uexp [2];
    logic [SW-1:0]          w_sig  [2];

    assign w_op[0] = r_a;
    assign w_op[1] = r_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            logic [NEXP-1:0] w_efld;
            logic [NSIG-1:0] w_mfld;
            assign w_efld = w_op[gi][W-2:NSIG];
            assign w_mfld = w_op[gi][NSIG-1:0];
            assign w_cls[gi] = (w_efld == '1) ? ((w_mfld == '0) ? C_INF :
                                                 (w_mfld[NSIG-1] ? C_QNAN : C_SNAN)) :
                               (w_efld == '0) ? ((w_mfld == '0) ? C_ZERO : C_SUB) : C_NORMAL;
            assign w_uexp[gi] = (w_efld == '0) ? EMIN : $signed({2'b00, w_efld}) - BIAS;
            assign w_sig[gi]  = {(w_efld != '0), w_mfld};
        end
    endgenerate

    logic         w_sign, w_any_snan, w_any_qnan, w_any_inf, w_any_zero, w_inf_zero;
    logic         w_special;
    logic [W-1:0] w_spec_y;
    logic [3:0]   w_spec_flags;

    assign w_sign     = r_a[W-1] ^ r_b[W-1];
    assign w_any_snan = (w_cls[0] == C_SNAN) || (w_cls[1] == C_SNAN);
    assign w_any_qnan = (w_cls[0] == C_QNAN) || (w_cls[1] == C_QNAN);
    assign w_any_inf  = (w_cls[0] == C_INF)  || (w_cls[1] == C_INF);
    assign w_any_zero = (w_cls[0] == C_ZERO) || (w_cls[1] == C_ZERO);
    assign w_inf_zero = ((w_cls[0] == C_INF) && (w_cls[1] == C_ZERO)) ||
                        ((w_cls[0] == C_ZERO) && (w_cls[1] == C_INF));

    // NaN outranks infinity, which outranks zero.
    always_comb begin
        w_special    = 1'b1;
        w_spec_y     = '0;
        w_spec_flags = 4'b0000;
        if (w_any_snan || w_inf_zero) begin
            w_spec_y     = QNAN;
            w_spec_flags = 4'b1000;
        end else if (w_any_qnan) begin
            w_spec_y = QNAN;
        end else if (w_any_inf) begin
            w_spec_y = {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
        end else if (w_any_zero) begin
            w_spec_y = {w_sign, {(W-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // Rounding: hidden bit sits at 2*NSIG, guard just below the kept fraction.
    logic [SW-1:0]        w_mant;
    logic                 w_guard, w_stk, w_inc;
    logic [SW:0]          w_rsum;
    logic signed [EW-1:0] w_rexp;
    logic [NSIG-1:0]      w_frac;
    logic [W-1:0]         w_rnd_y;
    logic [3:0]           w_rnd_flags;

    assign w_mant  = r_prod[PW-2 -: SW];
    assign w_guard = r_prod[NSIG-1];
    assign w_stk   = (|r_prod[NSIG-2:0]) | r_sticky;
    assign w_inc   = w_guard & (w_stk | w_mant[0]);
    assign w_rsum  = {1'b0, w_mant} + {{SW{1'b0}}, w_inc};
    assign w_rexp  = w_rsum[SW] ? r_exp + ONE : r_exp;
    assign w_frac  = w_rsum[SW] ? w_rsum[NSIG:1] : w_rsum[NSIG-1:0];

    always_comb begin
        w_rnd_y     = {r_sign, NEXP'(w_rexp + BIAS), w_frac};
        w_rnd_flags = {3'b000, w_guard | w_stk};
        if (w_rexp > BIAS) begin
            w_rnd_y     = {r_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
            w_rnd_flags = 4'b0101;
        end else if (w_rexp < EMIN) begin
            w_rnd_y     = {r_sign, {(W-1){1'b0}}};
            w_rnd_flags = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = S_UNPACK;
            end
            S_UNPACK: w_state_next = w_special ? S_DONE : S_MUL;
            S_MUL:    if (r_cnt == CW'(NSIG)) w_state_next = S_NORM;
            S_NORM:   if (r_prod[PW-1] || r_prod[PW-2]) w_state_next = S_ROUND;
            S_ROUND:  w_state_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = S_IDLE;
            end
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_y      <= '0;
            r_flags  <= '0;
            r_sign   <= 1'b0;
            r_sticky <= 1'b0;
            r_exp    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a <= a;
                        r_b <= b;
                    end
                end
                S_UNPACK: begin
                    r_sign   <= w_sign;
                    r_exp    <= w_uexp[0] + w_uexp[1];
                    r_mcand  <= {{SW{1'b0}}, w_sig[0]};
                    r_mplier <= w_sig[1];
                    r_prod   <= '0;
                    r_sticky <= 1'b0;
                    r_cnt    <= '0;
                    if (w_special) begin
                        r_y     <= w_spec_y;
                        r_flags <= w_spec_flags;
                    end
                end
                S_MUL: begin
                    r_prod   <= r_prod + (r_mplier[0] ? r_mcand : '0);
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                end
                S_NORM: begin
                    if (r_prod[PW-1]) begin
                        r_prod   <= r_prod >> 1;
                        r_sticky <= r_sticky | r_prod[0];
                        r_exp    <= r_exp + ONE;
                    end else if (!r_prod[PW-2]) begin
                        r_prod <= r_prod << 1;
                        r_exp  <= r_exp - ONE;
                    end
                end
                S_ROUND: begin
                    r_y     <= w_rnd_y;
                    r_flags <= w_rnd_flags;
                end
                default: ;
            endcase
        end
    end

    assign y     = r_y;
    assign flags = r_flags;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq (half precision): table of operand pairs with
// hand-computed products, flags and latencies, plus reset and back-pressure sequences.
module tb_fp_mul_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic [3:0]  flags;

    int total = 0;
    int bad   = 0;

    fp_mul_seq #(.NEXP(5), .NSIG(10)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] y;
        logic [3:0]  fl;
        int          lat;
        bit          noise;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency counts clock edges from the accept edge (=1) to the edge raising out_valid.
    task automatic run_vec(input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic [15:0] ey, input logic [3:0] ef,
                           input int elat, input int hold, input bit noise);
        int lat;
        bit ok;
        logic [15:0] cap_y;
        logic [3:0]  cap_f;
        @(negedge clk);
        check("ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_v;
        lat = 0;
        ok  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (noise && lat >= 2 && lat <= 8) begin
                in_valid = ~in_valid;
                a = 16'h4000;
                b = 16'h4000;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("timeout", 32'(ok), 32'd1);
        cap_y = y;
        cap_f = flags;
        $display("op a=%h b=%h y=%h flags=%b latency=%0d", ta, tb_v, cap_y, cap_f, lat);
        check("y", 32'(cap_y), 32'(ey));
        check("flags", 32'(cap_f), 32'(ef));
        check("latency", 32'(lat), 32'(elat));
        if (ok) begin
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_y", 32'(y), 32'(cap_y));
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("post_valid", 32'(out_valid), 32'd0);
            check("post_ready", 32'(in_ready), 32'd1);
            check("post_y_kept", 32'(y), 32'(cap_y));
        end
    endtask

    initial begin
        int seen;
        vecs[0]  = '{16'h3C00, 16'h3E00, 16'h3E00, 4'b0000, 15, 1'b0};
        vecs[1]  = '{16'h4000, 16'h4200, 16'h4600, 4'b0000, 15, 1'b0};
        vecs[2]  = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000,  2, 1'b0};
        vecs[3]  = '{16'h7D00, 16'h3C00, 16'h7E00, 4'b1000,  2, 1'b0};
        vecs[4]  = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b0000,  2, 1'b0};
        vecs[5]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101, 15, 1'b0};
        vecs[6]  = '{16'h0400, 16'h3800, 16'h0000, 4'b0011, 15, 1'b0};
        vecs[7]  = '{16'h0001, 16'h3C00, 16'h0000, 4'b0011, 25, 1'b1};
        vecs[8]  = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0001, 15, 1'b0};
        vecs[9]  = '{16'h3C01, 16'h3E00, 16'h3E02, 4'b0001, 15, 1'b0};
        vecs[10] = '{16'h3C03, 16'h3E00, 16'h3E04, 4'b0001, 15, 1'b0};
        vecs[11] = '{16'h0200, 16'h4800, 16'h0C00, 4'b0000, 16, 1'b0};
        vecs[12] = '{16'hFC00, 16'h3C00, 16'hFC00, 4'b0000,  2, 1'b0};
        vecs[13] = '{16'h8000, 16'h4000, 16'h8000, 4'b0000,  2, 1'b0};
        vecs[14] = '{16'h7C00, 16'h7E00, 16'h7E00, 4'b0000,  2, 1'b0};
        vecs[15] = '{16'h0400, 16'h3C00, 16'h0400, 4'b0000, 15, 1'b0};
        vecs[16] = '{16'h7800, 16'h4000, 16'h7C00, 4'b0101, 15, 1'b0};
        vecs[17] = '{16'h3C00, 16'h7BFF, 16'h7BFF, 4'b0000, 15, 1'b0};
        vecs[18] = '{16'h0000, 16'h7D00, 16'h7E00, 4'b1000,  2, 1'b0};
        vecs[19] = '{16'h8000, 16'h7C00, 16'h7E00, 4'b1000,  2, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", 32'(y), 32'd0);
        check("reset_flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Put a result in y, then start an op and reset it while in MUL.
        run_vec(16'h3C00, 16'h3E00, 16'h3E00, 4'b0000, 15, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h4000;
        b = 16'h4200;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_y", 32'(y), 32'd0);
        check("midreset_flags", 32'(flags), 32'd0);
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midreset_dropped", 32'(seen), 32'd0);

        for (int i = 0; i < NV; i++)
            run_vec(vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].fl, vecs[i].lat, 0, vecs[i].noise);

        // Back-pressure: result must hold for 5 cycles without out_ready.
        run_vec(16'hC000, 16'h3800, 16'hBC00, 4'b0000, 15, 5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
